// File: rtl/alu_pkg.sv
// Shared ALU types and constants: opcode encoding and default datapath width.
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 32;

  typedef enum logic [2:0] {
    OpAdd   = 3'b000,
    OpSub   = 3'b001,
    OpOr    = 3'b010,
    OpAnd   = 3'b011,
    OpXor   = 3'b100,
    OpSlt   = 3'b101,
    OpSltu  = 3'b110,
    OpPassb = 3'b111
  } alu_op_t;

  // Every op other than ADD drives the adder in subtract mode; SLT/SLTU need A - B.
  function automatic logic op_is_sub(alu_op_t op);
    return op != OpAdd;
  endfunction

endpackage

// File: rtl/alu_addsub.sv
// Shared WIDTH+1-bit adder/subtractor: sum, carry-out (no-borrow when subtracting)
// and signed overflow. Feeds ADD, SUB, SLT, SLTU and the optional flags.
module alu_addsub
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sub_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o,
  output logic             ovf_o
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   full;

  always_comb begin
    b_eff   = sub_i ? ~b_i : b_i;
    // Two's-complement subtract: A + ~B + 1, the +1 entering as carry-in.
    full    = {1'b0, a_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_i};
    sum_o   = full[WIDTH-1:0];
    carry_o = full[WIDTH];
    ovf_o   = (a_i[WIDTH-1] == b_eff[WIDTH-1]) && (sum_o[WIDTH-1] != a_i[WIDTH-1]);
  end

endmodule

// File: rtl/arithmetic_logic_unit.sv
// Registered integer ALU with 1-cycle latency. Define ALU_FLAGS_EN to add the
// registered zero/negative/carry/overflow flag outputs.
module arithmetic_logic_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [2:0]       ALUop,
  input  logic [WIDTH-1:0] operand_1,
  input  logic [WIDTH-1:0] operand_2,
  output logic [WIDTH-1:0] result,
`ifdef ALU_FLAGS_EN
  output logic             flag_zero,
  output logic             flag_neg,
  output logic             flag_carry,
  output logic             flag_ovf,
`endif
  output logic             out_valid
);

  alu_op_t          op;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             ovf;
  logic             slt;
  logic             sltu;
  logic [WIDTH-1:0] alu_res;

  logic [WIDTH-1:0] result_d, result_q;
  logic             valid_d, valid_q;

  always_comb op = alu_op_t'(ALUop);

  alu_addsub #(
    .WIDTH (WIDTH)
  ) u_addsub (
    .a_i     (operand_1),
    .b_i     (operand_2),
    .sub_i   (op_is_sub(op)),
    .sum_o   (sum),
    .carry_o (carry),
    .ovf_o   (ovf)
  );

  always_comb begin
    // Sign of A - B corrected by overflow gives a true signed compare.
    slt     = sum[WIDTH-1] ^ ovf;
    sltu    = ~carry;
    alu_res = '0;
    unique case (op)
      OpAdd,
      OpSub:   alu_res = sum;
      OpOr:    alu_res = operand_1 | operand_2;
      OpAnd:   alu_res = operand_1 & operand_2;
      OpXor:   alu_res = operand_1 ^ operand_2;
      OpSlt:   alu_res = {{(WIDTH-1){1'b0}}, slt};
      OpSltu:  alu_res = {{(WIDTH-1){1'b0}}, sltu};
      OpPassb: alu_res = operand_2;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    valid_d  = in_valid;
    result_d = in_valid ? alu_res : result_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  assign result    = result_q;
  assign out_valid = valid_q;

`ifdef ALU_FLAGS_EN
  logic zero_d, zero_q;
  logic neg_d, neg_q;
  logic carry_d, carry_q;
  logic ovf_d, ovf_q;
  logic is_arith;

  always_comb begin
    is_arith = (op == OpAdd) || (op == OpSub);
    zero_d   = zero_q;
    neg_d    = neg_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    if (in_valid) begin
      zero_d  = (alu_res == '0);
      neg_d   = alu_res[WIDTH-1];
      carry_d = is_arith & carry;
      ovf_d   = is_arith & ovf;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      zero_q  <= zero_d;
      neg_q   <= neg_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign flag_zero  = zero_q;
  assign flag_neg   = neg_q;
  assign flag_carry = carry_q;
  assign flag_ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_arithmetic_logic_unit.sv
// Self-checking bench for arithmetic_logic_unit: directed cases plus random ops
// against an arithmetic reference model. Checks flags when ALU_FLAGS_EN is defined.
module tb_arithmetic_logic_unit;
  import alu_pkg::*;

  localparam longint MaxS = 64'sh7FFF_FFFF;
  localparam longint MinS = -64'sh8000_0000;

  typedef struct packed {
    logic [31:0] r;
    logic        z;
    logic        n;
    logic        c;
    logic        v;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [2:0]  ALUop = 3'd0;
  logic [31:0] operand_1 = '0;
  logic [31:0] operand_2 = '0;
  logic [31:0] result;
  logic        out_valid;
`ifdef ALU_FLAGS_EN
  logic        flag_zero, flag_neg, flag_carry, flag_ovf;
`endif

  int   tests = 0;
  int   failed = 0;
  exp_t exp_q = '0;

  always #5 clk = ~clk;

  arithmetic_logic_unit #(
    .WIDTH (32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .ALUop      (ALUop),
    .operand_1  (operand_1),
    .operand_2  (operand_2),
    .result     (result),
`ifdef ALU_FLAGS_EN
    .flag_zero  (flag_zero),
    .flag_neg   (flag_neg),
    .flag_carry (flag_carry),
    .flag_ovf   (flag_ovf),
`endif
    .out_valid  (out_valid)
  );

  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint ua, ub, sa, sb, t;
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e  = '0;
    case (op)
      3'd0: begin
        t   = ua + ub;
        e.r = t[31:0];
        e.c = (t > 64'sh0_FFFF_FFFF);
        t   = sa + sb;
        e.v = (t > MaxS) || (t < MinS);
      end
      3'd1: begin
        t   = ua - ub;
        e.r = t[31:0];
        e.c = (ua >= ub);
        t   = sa - sb;
        e.v = (t > MaxS) || (t < MinS);
      end
      3'd2: e.r = a | b;
      3'd3: e.r = a & b;
      3'd4: e.r = a ^ b;
      3'd5: e.r = (sa < sb) ? 32'd1 : 32'd0;
      3'd6: e.r = (ua < ub) ? 32'd1 : 32'd0;
      default: e.r = b;
    endcase
    e.z = (e.r == 32'd0);
    e.n = e.r[31];
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv)
    else begin
      failed++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  task automatic check_outputs(input string tag, input logic vld);
    chk({tag, "/result"}, result, exp_q.r);
    chk({tag, "/out_valid"}, {31'd0, out_valid}, {31'd0, vld});
`ifdef ALU_FLAGS_EN
    chk({tag, "/zero"}, {31'd0, flag_zero}, {31'd0, exp_q.z});
    chk({tag, "/neg"}, {31'd0, flag_neg}, {31'd0, exp_q.n});
    chk({tag, "/carry"}, {31'd0, flag_carry}, {31'd0, exp_q.c});
    chk({tag, "/ovf"}, {31'd0, flag_ovf}, {31'd0, exp_q.v});
`endif
  endtask

  // Called at a falling edge; inputs are sampled at the next rising edge.
  task automatic step(input string tag, input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] b);
    ALUop     = op;
    operand_1 = a;
    operand_2 = b;
    in_valid  = 1'b1;
    @(posedge clk);
    exp_q = model(op, a, b);
    @(negedge clk);
    check_outputs(tag, 1'b1);
  endtask

  task automatic idle(input string tag);
    in_valid  = 1'b0;
    ALUop     = 3'($urandom_range(0, 7));
    operand_1 = $urandom;
    operand_2 = $urandom;
    @(posedge clk);
    @(negedge clk);
    check_outputs(tag, 1'b0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    exp_q = '0;
    check_outputs("reset", 1'b0);
    rst_n = 1'b1;

    step("add_5_6",     3'd0, 32'd5, 32'd6);
    step("sub_7_3",     3'd1, 32'd7, 32'd3);
    step("or_3_1",      3'd2, 32'd3, 32'd1);
    step("and_3_5",     3'd3, 32'd3, 32'd5);
    step("xor_5_2",     3'd4, 32'd5, 32'd2);
    step("passb",       3'd7, 32'hDEAD_BEEF, 32'h1234_5000);
    step("slt_neg6_4",  3'd5, 32'hFFFF_FFFA, 32'd4);
    step("sltu_neg6_4", 3'd6, 32'hFFFF_FFFA, 32'd4);
    step("sltu_5_6",    3'd6, 32'd5, 32'd6);
    step("slt_ovf",     3'd5, 32'h8000_0000, 32'h7FFF_FFFF);
    step("slt_eq",      3'd5, 32'd5, 32'd5);
    step("sltu_eq",     3'd6, 32'd9, 32'd9);
    step("add_wrap",    3'd0, 32'hFFFF_FFFF, 32'd1);
    step("add_ovf",     3'd0, 32'h7FFF_FFFF, 32'd1);
    step("sub_borrow",  3'd1, 32'd3, 32'd7);
    step("sub_ovf",     3'd1, 32'h8000_0000, 32'd1);
    idle("hold1");
    idle("hold2");

    // Asynchronous reset between clock edges with a valid stream in flight.
    ALUop     = 3'd0;
    operand_1 = 32'd100;
    operand_2 = 32'd23;
    in_valid  = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    exp_q = '0;
    check_outputs("async_rst", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst_add", 3'd0, 32'd40, 32'd2);
    step("post_rst_sub", 3'd1, 32'd2, 32'd40);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        idle("rand_idle");
      end else begin
        ra = $urandom;
        case ($urandom_range(0, 3))
          0:       rb = ra;
          1:       rb = ra ^ 32'h8000_0000;
          default: rb = $urandom;
        endcase
        step("rand_op", 3'($urandom_range(0, 7)), ra, rb);
      end
    end

    in_valid = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
